down_counter_timer: RTL and testbench
=====================================

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, as the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1, as its single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, as its asynchronous active-low reset.
REQ-004 The block SHALL have port load, input, 1, as the parallel-load strobe, sampled on the rising edge of clk.
REQ-005 The block SHALL have port load_val, input, WIDTH, as the value to load and the reload value.
REQ-006 The block SHALL have port en, input, 1, as the count enable; it decrements when high.
REQ-007 The block SHALL have port count_out, output, WIDTH, as the registered counter value.
REQ-008 The block SHALL have port zero, output, 1, which is high while count_out == 0.
REQ-009 The block SHALL have port tc, output, 1, as a registered one-cycle terminal-count pulse.
REQ-010 The block SHALL have port busy, output, 1, which is high in states RUN and PAUSE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-012 Load SHALL take priority over counting: on an edge with load=1, count_out <= load_val and reload_reg <= load_val, in any state.
REQ-013 On load, the next state SHALL be RUN if load_val != 0, else IDLE; tc SHALL be 0 that cycle regardless of en.
REQ-014 In RUN with en=1 and load=0, count_out SHALL decrement by exactly 1 per edge; latency from en high to first decrement is 1 edge.
REQ-015 In RUN with en=0, count_out SHALL hold and the FSM SHALL go to PAUSE; in PAUSE with en=1, it SHALL decrement and return to RUN on the same edge.
REQ-016 On an enabled decrement from 1 to 0, tc SHALL be 1 for exactly the cycle in which count_out first reads 0; tc SHALL be 0 at all other times.
REQ-017 Without auto-reload, after reaching 0 the FSM SHALL go to IDLE and count_out SHALL hold at 0.
REQ-018 In IDLE, en SHALL have no effect: no underflow and no wrap from 0 to 2^WIDTH-1.
REQ-019 The maximum load value 2^WIDTH-1 SHALL count down through every value to 0 in 2^WIDTH-1 enabled edges.
REQ-020 zero SHALL be combinationally derived from count_out; count_out, tc, busy and state SHALL be registered.

Reset
REQ-021 Assertion of reset (reset=0) SHALL immediately, without waiting for a clock edge, force count_out=0, reload_reg=0, tc=0 and state=IDLE, giving busy=0 and zero=1.
REQ-022 Reset asserted mid-count SHALL abort the count; no tc pulse SHALL be produced by the aborted count.
REQ-023 After reset deasserts, the block SHALL act on the first rising edge of clk and SHALL ignore en until a load occurs.

Configuration
REQ-024 When macro DOWN_COUNTER_TIMER_AUTO_RELOAD_EN is defined, the enabled edge following the tc cycle SHALL load reload_reg into count_out and remain in RUN, for a period of reload_reg+1 enabled edges; if reload_reg == 0, the FSM SHALL go to IDLE.
REQ-025 When DOWN_COUNTER_TIMER_AUTO_RELOAD_EN is undefined, reload_reg and its logic SHALL be absent and REQ-017 SHALL apply.
REQ-026 With DOWN_COUNTER_TIMER_AUTO_RELOAD_EN defined, when the state is RUN and count_out == 0, en=0 SHALL hold at 0 in PAUSE until en returns.

Verification
REQ-027 The bench SHALL cover: reset=0 for 200 ns, then release with en=1 and no load -> count_out=0, zero=1, busy=0, tc never 1.
REQ-028 The bench SHALL cover: load=1 with load_val=4'd5, then en=1 -> count_out 5,4,3,2,1,0 on successive edges; tc=1 only at 0; busy falls to 0 the same edge.
REQ-029 The bench SHALL cover: load 4'd9 with en=1, en=0 for 3 cycles after count_out reads 6 -> count_out holds 6 in PAUSE with busy=1, then resumes at 5.
REQ-030 The bench SHALL cover: load 4'd3 and counting, with load=1 and load_val=4'd12 asserted on the edge where count_out would go 1->0 -> count_out=12, tc=0, state RUN.
REQ-031 The bench SHALL cover: reset=0 pulsed asynchronously between edges while count_out=7 -> count_out=0 before the next edge, no tc.
REQ-032 The bench SHALL cover, with the macro defined: load 4'd2, en=1 -> count_out sequence 2,1,0,2,1,0, with tc=1 at each 0.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with IDLE/RUN/PAUSE control and a registered terminal-count pulse.
// Latency: one clk edge from load/en to count_out/tc/busy; zero follows count_out combinationally.
// Backpressure: none; en gates counting and dropping it in RUN parks the timer in PAUSE.
// Optional feature: DOWN_COUNTER_TIMER_AUTO_RELOAD_EN enables periodic reload from reload_reg.
`timescale 1ns/1ps
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count_out,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_reg <= '0;
        end else if (load) begin
            reload_reg <= load_val;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count_out;
        tc_nxt    = 1'b0;
        if (load) begin
            count_nxt = load_val;
            state_nxt = (load_val != '0) ? RUN : IDLE;
        end else begin
            case (state)
                RUN, PAUSE: begin
                    if (!en) begin
                        state_nxt = PAUSE;
                    end else if (count_out != '0) begin
                        count_nxt = count_out - WIDTH'(1);
                        state_nxt = RUN;
                        if (count_out == WIDTH'(1)) begin
                            tc_nxt = 1'b1;
`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                            state_nxt = IDLE;
`endif
                        end
                    end else begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                        // Enabled edge after the tc cycle starts the next period.
                        count_nxt = reload_reg;
                        state_nxt = (reload_reg != '0) ? RUN : IDLE;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count_out <= '0;
            tc        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            count_out <= count_nxt;
            tc        <= tc_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    assign zero = (count_out == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus randomized traffic vs a timer model.
`timescale 1ns/1ps
module tb_down_counter_timer;

    localparam int W = 4;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [W-1:0] count_out;
    logic         zero;
    logic         tc;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current value, stored period, whether a countdown is live, last tc.
    int m_val = 0;
    int m_rel = 0;
    bit m_act = 1'b0;
    bit m_tc  = 1'b0;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_val  (load_val),
        .en        (en),
        .count_out (count_out),
        .zero      (zero),
        .tc        (tc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_val = 0;
        m_rel = 0;
        m_act = 1'b0;
        m_tc  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else if (load) begin
            m_val = int'(load_val);
            m_rel = int'(load_val);
            m_act = (load_val != 0);
            m_tc  = 1'b0;
        end else if (m_act && en) begin
            if (m_val > 0) begin
                m_val = m_val - 1;
                m_tc  = (m_val == 0);
                if (m_val == 0 && !AR) m_act = 1'b0;
            end else begin
                m_val = m_rel;
                m_act = (m_rel != 0);
                m_tc  = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;
        #200;
        n_checks++;
        if (count_out !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got count=%0d zero=%b busy=%b tc=%b expected 0 1 0 0",
                     count_out, zero, busy, tc);
        end
        reset = 1'b1;
        en = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (count_out !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_en: cycle %0d got count=%0d zero=%b busy=%b tc=%b expected 0 1 0 0",
                         i, count_out, zero, busy, tc);
            end
        end
    endtask

    task automatic test_load_count();
        load = 1'b1; load_val = 4'd5; en = 1'b0;
        tick();
        n_checks++;
        if (count_out !== 4'd5 || busy !== 1'b1 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load5: got count=%0d busy=%b tc=%b expected 5 1 0", count_out, busy, tc);
        end
        load = 1'b0; en = 1'b1;
        for (int e = 4; e >= 0; e--) begin
            tick();
            n_checks++;
            if (count_out !== W'(e) || tc !== (e == 0) || busy !== (AR || e != 0) || zero !== (e == 0)) begin
                n_fail++;
                $display("FAIL count5: got count=%0d tc=%b busy=%b zero=%b expected %0d %b %b %b",
                         count_out, tc, busy, zero, e, (e == 0), (AR || e != 0), (e == 0));
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (count_out !== W'(m_val) || tc !== m_tc || busy !== m_act) begin
                n_fail++;
                $display("FAIL after_zero: got count=%0d tc=%b busy=%b expected %0d %b %b",
                         count_out, tc, busy, m_val, m_tc, m_act);
            end
        end
    endtask

    task automatic test_pause();
        load = 1'b1; load_val = 4'd9; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (count_out !== 4'd6) begin
            n_fail++;
            $display("FAIL pause_reach6: got %0d expected 6", count_out);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (count_out !== 4'd6 || busy !== 1'b1 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold: got count=%0d busy=%b tc=%b expected 6 1 0", count_out, busy, tc);
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (count_out !== 4'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_resume: got count=%0d busy=%b expected 5 1", count_out, busy);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 4'd3; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        n_checks++;
        if (count_out !== 4'd1) begin
            n_fail++;
            $display("FAIL prio_reach1: got %0d expected 1", count_out);
        end
        load = 1'b1; load_val = 4'd12;
        tick();
        n_checks++;
        if (count_out !== 4'd12 || tc !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_load12: got count=%0d tc=%b busy=%b expected 12 0 1", count_out, tc, busy);
        end
        load = 1'b0;
        tick();
        n_checks++;
        if (count_out !== 4'd11 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_run: got count=%0d tc=%b expected 11 0", count_out, tc);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd9; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        n_checks++;
        if (count_out !== 4'd7) begin
            n_fail++;
            $display("FAIL areset_reach7: got %0d expected 7", count_out);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (count_out !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got count=%0d zero=%b busy=%b tc=%b expected 0 1 0 0",
                     count_out, zero, busy, tc);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (count_out !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_aborted: cycle %0d got count=%0d tc=%b busy=%b expected 0 0 0",
                         i, count_out, tc, busy);
            end
        end
    endtask

    task automatic test_max();
        load = 1'b1; load_val = 4'd15; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 14; i >= 0; i--) begin
            tick();
            n_checks++;
            if (count_out !== W'(i) || tc !== (i == 0)) begin
                n_fail++;
                $display("FAIL max_count: got count=%0d tc=%b expected %0d %b", count_out, tc, i, (i == 0));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load     = ($urandom_range(0, 11) == 0);
            load_val = W'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (count_out !== W'(m_val) || tc !== m_tc || busy !== m_act || zero !== (m_val == 0)) begin
                n_fail++;
                $display("FAIL random: cycle %0d got count=%0d tc=%b busy=%b zero=%b expected %0d %b %b %b",
                         i, count_out, tc, busy, zero, m_val, m_tc, m_act, (m_val == 0));
            end
        end
        load = 1'b0;
    endtask

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    task automatic test_autoreload();
        logic [W-1:0] exp_c [5] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
        logic         exp_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        load = 1'b1; load_val = 4'd2; en = 1'b1;
        tick();
        n_checks++;
        if (count_out !== 4'd2) begin
            n_fail++;
            $display("FAIL ar_load2: got %0d expected 2", count_out);
        end
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (count_out !== exp_c[i] || tc !== exp_t[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ar_seq: step %0d got count=%0d tc=%b busy=%b expected %0d %b 1",
                         i, count_out, tc, busy, exp_c[i], exp_t[i]);
            end
        end
        en = 1'b0;
        tick();
        tick();
        n_checks++;
        if (count_out !== 4'd0 || busy !== 1'b1 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_pause0: got count=%0d busy=%b tc=%b expected 0 1 0", count_out, busy, tc);
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (count_out !== 4'd2 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_resume: got count=%0d tc=%b expected 2 0", count_out, tc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_count();
        test_pause();
        test_load_priority();
        test_async_reset();
        test_max();
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        test_autoreload();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
